// File: rtl/bus_slave_ram.sv
// rtl/bus_slave_ram.sv - pipelined request/ack/stall/err bus responder over a byte-lane RAM
module bus_slave_ram #(
  parameter int          DEPTH       = 1024,
  parameter logic [29:0] BASE_WORD   = 30'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [29:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam bit DIRECT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic           r_we;
  logic           r_hit;
  logic [3:0]     r_sel;
  logic [AW-1:0]  r_idx;
  logic [31:0]    r_wdata;
  logic [31:0]    r_data;
  logic           r_ack;
  logic           r_err;
  logic [31:0]    r_mem [DEPTH];

  logic           w_hit;
  logic           w_accept;
  logic           w_exec;
  logic           w_ex_we;
  logic           w_ex_hit;
  logic [3:0]     w_ex_sel;
  logic [AW-1:0]  w_ex_idx;
  logic [31:0]    w_ex_wdata;

  assign w_hit    = (addr_i[29:AW] == BASE_WORD[29:AW]);
  assign stall_o  = (r_state == S_WAIT);
  assign w_accept = rst_n & cyc_i & stb_i & ~stall_o;

  // With no wait states the request executes straight off the bus; otherwise from the latched copy.
  assign w_ex_we    = DIRECT ? we_i   : r_we;
  assign w_ex_hit   = DIRECT ? w_hit  : r_hit;
  assign w_ex_sel   = DIRECT ? sel_i  : r_sel;
  assign w_ex_idx   = DIRECT ? addr_i[AW-1:0] : r_idx;
  assign w_ex_wdata = DIRECT ? data_i : r_wdata;

  always_comb begin
    w_next = r_state;
    w_exec = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_next = DIRECT ? S_RESP : S_WAIT;
          w_exec = DIRECT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next = S_RESP;
          w_exec = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_sel   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_data  <= 32'h0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_exec & w_ex_hit;
      r_err   <= w_exec & ~w_ex_hit;
      if (w_exec && w_ex_hit && !w_ex_we) begin
        r_data <= r_mem[w_ex_idx];
      end
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_we    <= we_i;
        r_hit   <= w_hit;
        r_sel   <= sel_i;
        r_idx   <= addr_i[AW-1:0];
        r_wdata <= data_i;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_exec && w_ex_hit && w_ex_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_ex_sel[b]) r_mem[w_ex_idx][8*b +: 8] <= w_ex_wdata[8*b +: 8];
      end
    end
  end

  assign data_o = r_data;
  assign ack_o  = r_ack;
  assign err_o  = r_err;

endmodule

// File: tb/tb_bus_slave_ram.sv
// tb/tb_bus_slave_ram.sv - scoreboard bench for bus_slave_ram at 0, 2 and 3 wait states
module tb_bus_slave_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic [3:0]  sel [3];
  logic [29:0] addr[3];
  logic [31:0] wdat[3];
  logic [31:0] rdat[3];
  logic        ack [3];
  logic        stall[3];
  logic        err [3];

  always #5 clk = ~clk;

  bus_slave_ram #(.DEPTH(1024), .BASE_WORD(30'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .sel_i(sel[0]),
    .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]), .ack_o(ack[0]), .stall_o(stall[0]), .err_o(err[0]));
  bus_slave_ram #(.DEPTH(1024), .BASE_WORD(30'h0), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .sel_i(sel[1]),
    .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]), .ack_o(ack[1]), .stall_o(stall[1]), .err_o(err[1]));
  bus_slave_ram #(.DEPTH(1024), .BASE_WORD(30'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]), .sel_i(sel[2]),
    .addr_i(addr[2]), .data_i(wdat[2]), .data_o(rdat[2]), .ack_o(ack[2]), .stall_o(stall[2]), .err_o(err[2]));

  typedef struct {
    int          inst;
    bit          err;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  int   stall0_hi = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc_cnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && stall[0]) stall0_hi++;
    for (int k = 0; k < 3; k++) begin
      if (ack[k] || err[k]) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_completion: inst %0d ack=%b err=%b, none expected (cycle %0d)", k, ack[k], err[k], cyc_cnt);
        end else begin
          e = q.pop_front();
          check("resp_inst", 32'(k), 32'(e.inst));
          check("resp_err", 32'(err[k]), 32'(e.err));
          check("resp_ack", 32'(ack[k]), 32'(!e.err));
          check("resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
          if (e.chk) check("resp_data", rdat[k], e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit c, input bit s, input bit w, input logic [3:0] sl,
                       input logic [29:0] a, input logic [31:0] d);
    cyc[k] = c; stb[k] = s; we[k] = w; sel[k] = sl; addr[k] = a; wdat[k] = d;
  endtask

  task automatic expect_resp(input int k, input bit e, input bit c, input logic [31:0] d, input int lat);
    q.push_back('{inst: k, err: e, chk: c, data: d, cyc: cyc_cnt + lat});
  endtask

  task automatic req0(input bit w, input logic [3:0] sl, input logic [29:0] a, input logic [31:0] d,
                      input bit e, input bit c, input logic [31:0] xd);
    drive(0, 1'b1, 1'b1, w, sl, a, d);
    expect_resp(0, e, c, xd, 1);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      check("rst_ack", 32'(ack[k]), 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
      check("rst_stall", 32'(stall[k]), 32'd0);
      check("rst_data", rdat[k], 32'h0);
    end
    rst_n = 1'b1;
    step();

    // zero wait states: back-to-back traffic, lanes, window misses
    req0(1'b1, 4'hF, 30'h000, 32'h12345678, 1'b0, 1'b0, 32'h0);
    req0(1'b1, 4'hF, 30'h005, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    req0(1'b0, 4'hF, 30'h005, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    req0(1'b1, 4'h5, 30'h005, 32'h11223344, 1'b0, 1'b0, 32'h0);
    req0(1'b0, 4'hF, 30'h005, 32'h0,        1'b0, 1'b1, 32'hDE22BE44);
    req0(1'b0, 4'h0, 30'h005, 32'h0,        1'b0, 1'b1, 32'hDE22BE44);
    req0(1'b1, 4'hF, 30'h006, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
    req0(1'b1, 4'h0, 30'h006, 32'h00000000, 1'b0, 1'b0, 32'h0);
    req0(1'b0, 4'hF, 30'h006, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5);
    req0(1'b0, 4'hF, 30'h400, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5);
    req0(1'b1, 4'hF, 30'h400, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hA5A5A5A5);
    req0(1'b1, 4'hF, 30'h405, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hA5A5A5A5);
    req0(1'b0, 4'hF, 30'h000, 32'h0,        1'b0, 1'b1, 32'h12345678);
    req0(1'b0, 4'hF, 30'h005, 32'h0,        1'b0, 1'b1, 32'hDE22BE44);
    req0(1'b1, 4'hF, 30'h3FF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    req0(1'b0, 4'hF, 30'h3FF, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    step(); step(); step();

    // two wait states: a strobe held through the stall is taken only once stall drops
    drive(1, 1'b1, 1'b1, 1'b1, 4'hF, 30'h001, 32'h0BADCAFE);
    expect_resp(1, 1'b0, 1'b0, 32'h0, 3);
    step();
    drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 30'h001, 32'h0);
    check("ws2_stall_n1", 32'(stall[1]), 32'd1);
    step();
    check("ws2_stall_n2", 32'(stall[1]), 32'd1);
    step();
    check("ws2_stall_n3", 32'(stall[1]), 32'd0);
    expect_resp(1, 1'b0, 1'b1, 32'h0BADCAFE, 3);
    step();
    drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    check("ws2_stall_rd", 32'(stall[1]), 32'd1);
    step(); step(); step(); step();
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    step();

    // three wait states: abort drops the write, later read sees old data
    drive(2, 1'b1, 1'b1, 1'b1, 4'hF, 30'h002, 32'h55AA55AA);
    expect_resp(2, 1'b0, 1'b0, 32'h0, 4);
    step();
    drive(2, 1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    step(); step(); step(); step(); step();
    drive(2, 1'b1, 1'b1, 1'b1, 4'hF, 30'h002, 32'hFFFFFFFF);
    step();
    drive(2, 1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    step();
    drive(2, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    check("abort_stall2", 32'(stall[2]), 32'd1);
    step();
    check("abort_idle", 32'(stall[2]), 32'd0);
    step(); step();
    drive(2, 1'b1, 1'b1, 1'b0, 4'hF, 30'h002, 32'h0);
    expect_resp(2, 1'b0, 1'b1, 32'h55AA55AA, 4);
    step();
    drive(2, 1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    step(); step(); step(); step(); step();

    // asynchronous reset in the middle of a wait
    drive(2, 1'b1, 1'b1, 1'b0, 4'hF, 30'h002, 32'h0);
    step();
    drive(2, 1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    check("rst_pre_stall", 32'(stall[2]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall[2]), 32'd0);
    check("arst_ack", 32'(ack[2]), 32'd0);
    check("arst_err", 32'(err[2]), 32'd0);
    check("arst_data", rdat[2], 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(); step(); step(); step(); step(); step();
    drive(2, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    step();

    check("queue_drained", 32'(q.size()), 32'd0);
    check("ws0_no_stall", 32'(stall0_hi), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
